// File: rtl/ws2812_status_chain_pkg.sv
// Shared definitions for the WS2812 status chain: 50 MHz timing defaults,
// GRB field layout, FSM state codes and small sizing/colour helpers.
package ws2812_status_chain_pkg;

   localparam int          DEF_NLEDS    = 5;
   localparam logic [23:0] DEF_ON_GRB   = 24'h100000;
   localparam logic [23:0] DEF_OFF_GRB  = 24'h000000;
   localparam int          DEF_TBIT     = 63;
   localparam int          DEF_T0H      = 20;
   localparam int          DEF_T1H      = 40;
   localparam int          DEF_TRESET   = 15000;
   localparam int          DEF_TREFRESH = 1000000;

   // One pixel is 24 bits on the wire: G[23:16], R[15:8], B[7:0], MSB first.
   localparam int GRB_BITS  = 24;
   localparam int GRB_G_MSB = 23;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_BIT   = 2'd2;
   localparam logic [1:0] ST_LATCH = 2'd3;

   // Width needed to hold values 0..max_val without wrapping.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic logic [GRB_BITS-1:0] grb_colour(
      input logic                lit,
      input logic [GRB_BITS-1:0] on_c,
      input logic [GRB_BITS-1:0] off_c
   );
      return lit ? on_c : off_c;
   endfunction

endpackage

// File: rtl/ws2812_status_chain_bit_tx.sv
// One WS2812 NRZ symbol generator: a start strobe launches a TBIT-long symbol,
// high for T1H or T0H cycles; o_done marks its final cycle.
module ws2812_status_chain_bit_tx
   import ws2812_status_chain_pkg::*;
#(
   parameter int TBIT = DEF_TBIT,
   parameter int T0H  = DEF_T0H,
   parameter int T1H  = DEF_T1H
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_start,
   input  logic i_bit,
   output logic o_done,
   output logic o_dout
);

   localparam int CW = cnt_width(TBIT - 1);

   logic [CW-1:0] r_cnt;
   logic          r_bit;
   logic          r_active;
   logic          r_dout;
   logic [CW-1:0] w_high;

   assign w_high = r_bit ? CW'(T1H) : CW'(T0H);
   assign o_done = r_active && (r_cnt == CW'(TBIT - 1));
   assign o_dout = r_dout;

   // The wire is registered so it trails the symbol counter by one cycle;
   // a start in the same cycle as o_done chains symbols with no gap.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_bit    <= 1'b0;
         r_active <= 1'b0;
         r_dout   <= 1'b0;
      end else begin
         r_dout <= r_active && (r_cnt < w_high);
         if (i_start) begin
            r_bit    <= i_bit;
            r_cnt    <= '0;
            r_active <= 1'b1;
         end else if (o_done) begin
            r_active <= 1'b0;
         end else if (r_active) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ws2812_status_chain.sv
// Status-LED chain driver: maps each status bit to a GRB colour and streams
// the frame on change, on force, or periodically for pixel recovery.
module ws2812_status_chain
   import ws2812_status_chain_pkg::*;
#(
   parameter int          NLEDS    = DEF_NLEDS,
   parameter logic [23:0] ON_GRB   = DEF_ON_GRB,
   parameter logic [23:0] OFF_GRB  = DEF_OFF_GRB,
   parameter int          TBIT     = DEF_TBIT,
   parameter int          T0H      = DEF_T0H,
   parameter int          T1H      = DEF_T1H,
   parameter int          TRESET   = DEF_TRESET,
   parameter int          TREFRESH = DEF_TREFRESH
) (
   input  logic             clk_p,
   input  logic             rst,
   input  logic [NLEDS-1:0] led,
   input  logic             force_req,
   output logic             led2812,
   output logic             busy
);

   if (!((T0H < T1H) && (T1H < TBIT) && (NLEDS >= 1))) begin : g_bad_params
      $fatal(1, "ws2812_status_chain: need T0H < T1H < TBIT and NLEDS >= 1");
   end

   localparam int PW = cnt_width(NLEDS - 1);
   localparam int BW = cnt_width(GRB_G_MSB);
   localparam int LW = cnt_width(TRESET - 1);
   localparam int RW = cnt_width(TREFRESH - 1);

   logic [1:0]          r_state;
   logic [NLEDS-1:0]    r_snap;
   logic [GRB_BITS-1:0] r_shift;
   logic [BW-1:0]       r_bit_cnt;
   logic [PW-1:0]       r_pix;
   logic [LW-1:0]       r_lat_cnt;
   logic [RW-1:0]       r_ref_cnt;
   logic                r_force_pend;
   logic                r_busy;

   logic                w_done;
   logic                w_start;
   logic                w_start_bit;
   logic [GRB_BITS-1:0] w_next_shift;
   logic [PW-1:0]       w_pix_next;
   logic                w_last_bit;
   logic                w_last_pix;
   logic                w_refresh_due;
   logic                w_frame_req;

   assign w_pix_next    = r_pix + 1'b1;
   assign w_last_bit    = (r_bit_cnt == '0);
   assign w_last_pix    = (r_pix == PW'(NLEDS - 1));
   assign w_refresh_due = (r_ref_cnt == RW'(TREFRESH - 1));
   assign w_frame_req   = (led != r_snap) || force_req || r_force_pend || w_refresh_due;

   // Pixel 0 comes straight from led because the snapshot is written in the same cycle.
   always_comb begin
      w_start      = 1'b0;
      w_next_shift = r_shift;
      case (r_state)
         ST_LOAD: begin
            w_start      = 1'b1;
            w_next_shift = grb_colour(led[0], ON_GRB, OFF_GRB);
         end
         ST_BIT: begin
            if (w_done) begin
               if (!w_last_bit) begin
                  w_start      = 1'b1;
                  w_next_shift = r_shift << 1;
               end else if (!w_last_pix) begin
                  w_start      = 1'b1;
                  w_next_shift = grb_colour(r_snap[w_pix_next], ON_GRB, OFF_GRB);
               end
            end
         end
         default: ;
      endcase
      w_start_bit = w_next_shift[GRB_G_MSB];
   end

   ws2812_status_chain_bit_tx #(
      .TBIT (TBIT),
      .T0H  (T0H),
      .T1H  (T1H)
   ) u_bit_tx (
      .i_clk   (clk_p),
      .i_rst   (rst),
      .i_start (w_start),
      .i_bit   (w_start_bit),
      .o_done  (w_done),
      .o_dout  (led2812)
   );

   // Reset lands in LATCH so a frame cut short by rst is never latched as valid.
   always_ff @(posedge clk_p or posedge rst) begin
      if (rst) begin
         r_state      <= ST_LATCH;
         r_snap       <= '0;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_pix        <= '0;
         r_lat_cnt    <= '0;
         r_ref_cnt    <= '0;
         r_force_pend <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_shift <= w_next_shift;

         if (force_req && (r_state != ST_IDLE)) begin
            r_force_pend <= 1'b1;
         end else if (r_state == ST_LOAD) begin
            r_force_pend <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_frame_req) begin
                  r_state <= ST_LOAD;
               end else if (!w_refresh_due) begin
                  r_ref_cnt <= r_ref_cnt + 1'b1;
               end
            end
            ST_LOAD: begin
               r_snap    <= led;
               r_pix     <= '0;
               r_bit_cnt <= BW'(GRB_G_MSB);
               r_ref_cnt <= '0;
               r_busy    <= 1'b1;
               r_state   <= ST_BIT;
            end
            ST_BIT: begin
               if (w_done) begin
                  if (!w_last_bit) begin
                     r_bit_cnt <= r_bit_cnt - 1'b1;
                  end else if (!w_last_pix) begin
                     r_pix     <= w_pix_next;
                     r_bit_cnt <= BW'(GRB_G_MSB);
                  end else begin
                     r_lat_cnt <= '0;
                     r_state   <= ST_LATCH;
                  end
               end
            end
            default: begin
               if (r_lat_cnt == LW'(TRESET - 1)) begin
                  r_state   <= ST_IDLE;
                  r_busy    <= 1'b0;
                  r_ref_cnt <= '0;
               end else begin
                  r_lat_cnt <= r_lat_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign busy = r_busy;

endmodule

// File: tb/tb_ws2812_status_chain.sv
// Bench for ws2812_status_chain: decodes the serial wire into frames and checks
// them against a frame-level model of the change/force/refresh/latch rules.
module tb_ws2812_status_chain;

   localparam int          NLEDS    = 2;
   localparam int          TBIT     = 10;
   localparam int          T0H      = 3;
   localparam int          T1H      = 6;
   localparam int          TRESET   = 20;
   localparam int          TREFRESH = 200;
   localparam logic [23:0] ON_GRB   = 24'h800001;
   localparam logic [23:0] OFF_GRB  = 24'h000000;
   localparam int          FBITS    = 24 * NLEDS;
   localparam int          DATA     = FBITS * TBIT;

   logic             clk_p = 1'b0;
   logic             rst = 1'b1;
   logic             force_req = 1'b0;
   logic [NLEDS-1:0] led = '0;
   logic             led2812;
   logic             busy;

   ws2812_status_chain #(
      .NLEDS(NLEDS), .ON_GRB(ON_GRB), .OFF_GRB(OFF_GRB), .TBIT(TBIT),
      .T0H(T0H), .T1H(T1H), .TRESET(TRESET), .TREFRESH(TREFRESH)
   ) dut (
      .clk_p     (clk_p),
      .rst       (rst),
      .led       (led),
      .force_req (force_req),
      .led2812   (led2812),
      .busy      (busy)
   );

   initial forever #5 clk_p = ~clk_p;

   typedef struct {
      int               start;
      logic [FBITS-1:0] val;
      int               nsym;
      bit               bad;
      int               gap;
   } frame_t;

   frame_t frame_q[$];
   int     busy_q[$];
   int     cyc = 0;
   int     n_starts = 0;
   int     n_cmp = 0;
   int     n_mis = 0;

   initial forever begin
      @(posedge clk_p);
      cyc++;
   end

   // Wire decoder: high width classifies each symbol, a low run of TBIT ends a frame.
   initial begin : monitor
      frame_t cur;
      bit     in_frame = 0;
      bit     prev = 0;
      int     high_run = 0;
      int     low_run = 0;
      int     sym_rise = 0;
      int     b_run = 0;
      forever begin
         @(negedge clk_p);
         if (led2812 === 1'b1) begin
            if (!prev) begin
               if (!in_frame) begin
                  in_frame  = 1;
                  cur.start = cyc;
                  cur.val   = '0;
                  cur.nsym  = 0;
                  cur.bad   = 0;
                  cur.gap   = low_run;
                  n_starts++;
               end else if (cyc - sym_rise != TBIT) begin
                  cur.bad = 1;
               end
               sym_rise = cyc;
               high_run = 0;
            end
            high_run++;
            low_run = 0;
            prev = 1;
         end else begin
            if (prev) begin
               cur.nsym++;
               cur.val = {cur.val[FBITS-2:0], (high_run == T1H)};
               if (high_run != T1H && high_run != T0H) cur.bad = 1;
            end
            low_run++;
            if (in_frame && low_run == TBIT) begin
               frame_q.push_back(cur);
               in_frame = 0;
            end
            prev = 0;
         end
         if (busy === 1'b1) begin
            b_run++;
         end else if (b_run != 0) begin
            busy_q.push_back(b_run);
            b_run = 0;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference: pixel p occupies bits [FBITS-1-24p -: 24], lit -> ON colour.
   function automatic logic [FBITS-1:0] expect_frame(input logic [NLEDS-1:0] l);
      logic [FBITS-1:0] v;
      v = '0;
      for (int p = 0; p < NLEDS; p++) v[FBITS-1-24*p -: 24] = l[p] ? ON_GRB : OFF_GRB;
      return v;
   endfunction

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_p);
         #1;
      end
   endtask

   task automatic wait_start(input int budget, output int s, output bit seen);
      int n0;
      n0 = n_starts;
      seen = 0;
      s = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk_p);
         #1;
         if (n_starts != n0) begin
            seen = 1;
            s = cyc;
         end
      end
   endtask

   task automatic pop_frame(output frame_t f, output bit ok);
      ok = 0;
      f.start = 0; f.val = '0; f.nsym = 0; f.bad = 1; f.gap = 0;
      for (int i = 0; i < 1000 && frame_q.size() == 0; i++) begin
         @(negedge clk_p);
         #1;
      end
      if (frame_q.size() != 0) begin
         f = frame_q.pop_front();
         ok = 1;
      end
   endtask

   task automatic pop_busy(output int b, output bit ok);
      ok = 0;
      b = 0;
      for (int i = 0; i < 1000 && busy_q.size() == 0; i++) begin
         @(negedge clk_p);
         #1;
      end
      if (busy_q.size() != 0) begin
         b = busy_q.pop_front();
         ok = 1;
      end
   endtask

   task automatic check_frame(input string tag, input frame_t f, input logic [FBITS-1:0] exp);
      check_eq({tag, "_val"}, f.val, exp);
      check_eq({tag, "_nsym"}, f.nsym, FBITS);
      check_eq({tag, "_symbol_shape"}, f.bad, 0);
   endtask

   task automatic run_window(input int len, input logic [NLEDS-1:0] nl, input int loff,
                             input int nf, input int f0, input int f1, input int f2);
      for (int off = 1; off <= len; off++) begin
         @(negedge clk_p);
         #1;
         force_req = (nf > 0 && off == f0) || (nf > 1 && off == f1) || (nf > 2 && off == f2);
         if (off == loff) led = nl;
      end
      force_req = 0;
   endtask

   initial begin : main
      frame_t           f;
      int               s, r, rel, c, b;
      int               loff, nf, f0, f1, f2;
      bit               ok, trig;
      logic [NLEDS-1:0] cur_led, new_led;

      step(3);
      check_eq("reset_led2812", led2812, 0);
      check_eq("reset_busy", busy, 0);
      rst = 0;
      rel = cyc;
      step(5);
      check_eq("post_reset_busy", busy, 0);
      check_eq("post_reset_led2812", led2812, 0);

      // No change and no force: latch, a full refresh wait, LOAD, then the first rise.
      wait_start(1000, s, ok);
      check_eq("first_frame_seen", ok, 1);
      check_eq("first_frame_delay", s - rel, TRESET + TREFRESH + 2);
      pop_frame(f, ok);
      check_eq("first_frame_popped", ok, 1);
      check_frame("first_frame", f, expect_frame(2'b00));
      check_eq("first_frame_gap", f.gap >= TRESET, 1);
      $display("frame start=%0d val=%h nsym=%0d", f.start, f.val, f.nsym);
      pop_busy(b, ok);
      check_eq("first_busy_len", b, DATA + TRESET);

      // Change driven after edge c is seen at edge c+1; the rise comes two edges later.
      step(5);
      led = 2'b01;
      c = cyc;
      wait_start(1000, s, ok);
      check_eq("latency_seen", ok, 1);
      check_eq("latency", s - c, 3);
      r = s;
      cur_led = 2'b01;

      for (int it = 0; it < 12; it++) begin
         f0 = 0; f1 = 0; f2 = 0; nf = 0; loff = 0;
         new_led = cur_led;
         case (it)
            0: begin new_led = 2'b10; loff = 200; end
            1: begin nf = 3; f0 = 50; f1 = 150; f2 = 400; end
            2: ;
            default: begin
               new_led = NLEDS'($urandom_range(3, 0));
               loff = $urandom_range(490, 5);
               nf = $urandom_range(3, 0);
               f0 = $urandom_range(480, 5);
               f1 = $urandom_range(480, 5);
               f2 = $urandom_range(480, 5);
            end
         endcase
         run_window(490, new_led, loff, nf, f0, f1, f2);
         trig = (new_led != cur_led) || (nf != 0);
         wait_start(2000, s, ok);
         check_eq("next_frame_seen", ok, 1);
         check_eq("frame_period", s - r, DATA + TRESET + (trig ? 1 : TREFRESH) + 1);
         pop_frame(f, ok);
         check_eq("frame_popped", ok, 1);
         check_frame("frame", f, expect_frame(cur_led));
         check_eq("interframe_gap", f.gap >= TRESET, 1);
         pop_busy(b, ok);
         check_eq("busy_len", b, DATA + TRESET);
         $display("it=%0d start=%0d val=%h next_led=%b forces=%0d period=%0d",
                  it, f.start, f.val, new_led, nf, s - r);
         cur_led = new_led;
         r = s;
      end

      // Reset in the high phase of bit 30, then a clean latch and a full frame.
      run_window(30 * TBIT + 1, cur_led, 0, 0, 0, 0, 0);
      check_eq("bit30_high", led2812, 1);
      rst = 1;
      #1;
      check_eq("async_rst_led2812", led2812, 0);
      check_eq("async_rst_busy", busy, 0);
      led = 2'b11;
      step(2);
      rst = 0;
      rel = cyc;
      wait_start(1000, s, ok);
      check_eq("after_rst_seen", ok, 1);
      check_eq("after_rst_delay", s - rel, TRESET + 1 + 2);
      pop_frame(f, ok);
      check_eq("truncated_popped", ok, 1);
      check_eq("truncated_nsym", f.nsym, 31);
      check_eq("truncated_bad", f.bad, 1);
      pop_busy(b, ok);
      pop_frame(f, ok);
      check_eq("after_rst_popped", ok, 1);
      check_frame("after_rst", f, expect_frame(2'b11));
      check_eq("after_rst_gap", f.gap >= TRESET, 1);
      $display("frame start=%0d val=%h nsym=%0d gap=%0d", f.start, f.val, f.nsym, f.gap);
      pop_busy(b, ok);
      check_eq("after_rst_busy_len", b, DATA + TRESET);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/ws2812_status_chain.md
Name: ws2812_status_chain

Overview:
- Serial driver for the on-board WS2812 status LED chain on the QMTECH board top.
- Consumes the status vector built from disk, MMU, WAIT, timer and sequencer indicators.
- Emits the single-wire NRZ stream on led2812.
- Maps each status bit to a fixed GRB colour, sends a frame on any change, and re-sends periodically so glitched pixels recover.

Parameters:
- NLEDS, 5, number of pixels in the chain; led[0] is the first pixel on the wire.
- ON_GRB, 24'h100000, colour sent for a lit status bit (G[23:16], R[15:8], B[7:0]).
- OFF_GRB, 24'h000000, colour sent for an unlit status bit.
- TBIT, 63, clk_p cycles per bit (1.26 us at 50 MHz).
- T0H, 20, high time of a 0 bit, in cycles.
- T1H, 40, high time of a 1 bit, in cycles.
- TRESET, 15000, minimum low latch time between frames, in cycles (300 us).
- TREFRESH, 1000000, cycles from frame end to forced re-send (20 ms).

Ports:
- clk_p, in, 1: processor clock, all logic on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- led, in, NLEDS: status bits, synchronous to clk_p, 1 = lit.
- force, in, 1: single-cycle request to re-send the frame.
- led2812, out, 1: serial data to the chain, idle low.
- busy, out, 1: high while a frame is being shifted out or latched.

Behaviour:
- Reset values: led2812=0, busy=0. The FSM enters LATCH with its counter cleared and last-sent snapshot = all zeros. The first frame starts only after TRESET low cycles.
- FSM states:
  - IDLE: start a frame (go to LOAD) when led != snapshot, force=1, or the refresh counter reaches TREFRESH-1.
  - LOAD: 1 cycle. Snapshot <= led. Pixel index = 0. Shift register <= snapshot[0] ? ON_GRB : OFF_GRB. Bit counter = 23. busy=1.
  - BIT: cycle counter 0..TBIT-1. led2812=1 while count < (current bit ? T1H : T0H), else 0. At count TBIT-1:
    - If bits remain: shift left and decrement.
    - Else if pixels remain: load the next pixel's colour with no gap cycle.
    - Else go to LATCH.
  - LATCH: led2812=0 for TRESET cycles, busy=1, then go to IDLE with busy=0 and the refresh counter cleared.
- Bit order: pixel 0 first, within a pixel G MSB first, then R, then B. One frame = 24*NLEDS bits, exactly 24*NLEDS*TBIT cycles of data.
- Latency: a change on led seen in IDLE at edge N produces the rising edge of the first bit at edge N+2 (IDLE→LOAD→BIT).
- The led vector is sampled only in LOAD. Changes during BIT or LATCH do not alter the frame in flight. They are compared against the snapshot in IDLE and trigger a new frame right after the latch.
- A force pulse during a frame is remembered in a pending flag, consumed at the next IDLE, and cleared in LOAD. Multiple pulses collapse to one frame.
- When change, force and refresh occur simultaneously, one frame is sent.
- The refresh counter runs only in IDLE. It saturates at TREFRESH-1 until LOAD.
- Counter widths are $clog2 of the largest value each counter holds. No wrap-around is permitted.
- rst asserted mid-frame: led2812 goes to 0 immediately (asynchronous). After release the chain receives a full TRESET latch before a complete new frame, so no truncated pixel is latched as valid.
- Parameter legality: T0H < T1H < TBIT and NLEDS ≥ 1. Simulation checks these and flags a fatal error otherwise.

Decomposition:
- Shared include/package ws2812_defs: default timing constants for 50 MHz, the GRB field positions, and the FSM state encodings.
- One sub-module, ws2812_bit_tx: given a bit value and a start strobe, produces one TBIT-long symbol and a done pulse. The top level owns the pixel/bit sequencing, snapshot, refresh and force logic.

Test Plan (bench params unless stated: NLEDS=2, TBIT=10, T0H=3, T1H=6, TRESET=20, TREFRESH=200, ON_GRB=24'h800001, OFF_GRB=0):
1. Reset release, led=2'b00 held: led2812 stays 0 for 20 cycles. With no change and no force, the first frame starts only at refresh. It carries 48 symbols, every one 3 cycles high / 7 cycles low.
2. led=2'b01 while in IDLE: the first symbol rises 2 cycles later. Pixel 0 decodes as 0x800001 (bit23=6-high, bit0=6-high, others 3-high). Pixel 1 decodes as 0x000000. busy stays high for 480+20 cycles.
3. led toggles to 2'b10 mid-frame: the current frame still decodes {0x800001, 0x000000}. A second frame decoding {0x000000, 0x800001} begins immediately after the 20-cycle latch.
4. Three force pulses during one frame: exactly one extra frame follows the latch, and busy drops after it.
5. No input activity: frames repeat every 200 + 500 cycles. The measured inter-frame low time is ≥ 20 cycles.
6. rst pulsed at bit 30 of a frame: led2812=0 in the same cycle. After release, ≥ 20 low cycles precede a complete 48-bit frame.
